// File: rtl/secam_filter_pkg.sv
// Shared SECAM chroma filter coefficients and fixed-point helpers.
// Used by both the transmit pre-emphasis and the receive de-emphasis blocks.
package secam_filter_pkg;

   localparam int A_PREC_DEF = 8;
   localparam int B_PREC_DEF = 8;
   localparam int COEF_W     = 16;
   localparam int STATE_W    = 11;
   localparam int DATA_W     = 9;

   // A1 sign: de-emphasis adds +A1*v[n-1] as feedback; pre-emphasis subtracts A1*x[n-1] as a feed-forward tap.
   // DC gain (B0+B1)/(2^B_PREC - A1) = 64/64 = 1.
   localparam logic signed [COEF_W-1:0] A1 = 16'sd192;
   localparam logic signed [COEF_W-1:0] B0 = 16'sd80;
   localparam logic signed [COEF_W-1:0] B1 = -16'sd16;

   // Pre-emphasis: e[n] = rnd(PE_GAIN*(x[n] - rnd(A1*x[n-1])), 8) + rnd(PE_FB*e[n-1], 8)
   localparam logic signed [COEF_W-1:0] PE_GAIN = 16'sd819;
   localparam logic signed [COEF_W-1:0] PE_FB   = 16'sd51;

   function automatic logic signed [31:0] rnd(input logic signed [31:0] p, input int s);
      return (p + (32'sd1 <<< (s - 1))) >>> s;
   endfunction

   function automatic int sat_hi(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int w);
      return -(1 << (w - 1));
   endfunction

   function automatic logic signed [10:0] sat11(input logic signed [31:0] v);
      if (v > 32'sd1023)
         return 11'sh3ff;
      if (v < -32'sd1024)
         return 11'sh400;
      return v[10:0];
   endfunction

   function automatic logic signed [8:0] sat9(input logic signed [31:0] v);
      if (v > 32'sd255)
         return 9'sh0ff;
      if (v < -32'sd256)
         return 9'sh100;
      return v[8:0];
   endfunction

endpackage

// File: rtl/round_sat_mul.sv
// Combinational signed multiply by a coefficient, round-half-up by SHIFT bits, clamp to OUT_W.
// Zero latency; no flow control of its own.
module round_sat_mul
   import secam_filter_pkg::*;
#(
   parameter int IN_W  = 11,
   parameter int SHIFT = 8,
   parameter int OUT_W = 11
)
(
   input  logic signed [IN_W-1:0]   din,
   input  logic signed [COEF_W-1:0] coef,
   output logic signed [OUT_W-1:0]  dout
);

   localparam int HI = sat_hi(OUT_W);
   localparam int LO = sat_lo(OUT_W);

   logic signed [31:0] prod;
   logic signed [31:0] rounded;

   assign prod    = 32'(din) * 32'(coef);
   assign rounded = rnd(prod, SHIFT);

   always_comb begin
      if (rounded > HI)
         dout = OUT_W'(HI);
      else if (rounded < LO)
         dout = OUT_W'(LO);
      else
         dout = rounded[OUT_W-1:0];
   end

endmodule

// File: rtl/filter_chroma_deemphasis.sv
// SECAM chroma de-emphasis IIR: input reg, state update, B multiplies, sum/saturate; 3-edge latency.
// Global stall while out_valid & ~out_ready; clear flushes state and pipeline even when stalled.
module filter_chroma_deemphasis
   import secam_filter_pkg::*;
#(
   parameter int A_PREC = A_PREC_DEF,
   parameter int B_PREC = B_PREC_DEF
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data
);

   logic stall;
   logic accept;

   logic                      s0_vld;
   logic signed [DATA_W-1:0]  s0_x;

   logic signed [STATE_W-1:0] v_state;
   logic signed [STATE_W-1:0] a_term;
   logic signed [31:0]        v_sum;
   logic signed [STATE_W-1:0] v_new;

   logic                      s1_vld;
   logic signed [STATE_W-1:0] s1_v;
   logic signed [STATE_W-1:0] s1_vp;

   logic signed [STATE_W-1:0] b0_term;
   logic signed [STATE_W-1:0] b1_term;

   logic                      s2_vld;
   logic signed [STATE_W-1:0] s2_b0;
   logic signed [STATE_W-1:0] s2_b1;
   logic signed [31:0]        y_sum;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall & ~clear;
   assign accept   = in_valid & in_ready;

   // S0: input register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_vld <= 1'b0;
         s0_x   <= '0;
      end else if (clear) begin
         s0_vld <= 1'b0;
      end else if (!stall) begin
         s0_vld <= accept;
         if (accept)
            s0_x <= in_data;
      end
   end

   // S1: recursive state update, v[n] = sat11(x[n] + rnd(A1*v[n-1]))
   round_sat_mul #(.IN_W(STATE_W), .SHIFT(A_PREC), .OUT_W(STATE_W)) u_mul_a1 (
      .din  (v_state),
      .coef (A1),
      .dout (a_term)
   );

   assign v_sum = 32'(s0_x) + 32'(a_term);
   assign v_new = sat11(v_sum);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_state <= '0;
         s1_vld  <= 1'b0;
         s1_v    <= '0;
         s1_vp   <= '0;
      end else if (clear) begin
         v_state <= '0;
         s1_vld  <= 1'b0;
      end else if (!stall) begin
         s1_vld <= s0_vld;
         if (s0_vld) begin
            s1_v    <= v_new;
            s1_vp   <= v_state;
            v_state <= v_new;
         end
      end
   end

   // S1 multiplies: the state is 11 bits and |B|/2^B_PREC < 1, so these never clip
   round_sat_mul #(.IN_W(STATE_W), .SHIFT(B_PREC), .OUT_W(STATE_W)) u_mul_b0 (
      .din  (s1_v),
      .coef (B0),
      .dout (b0_term)
   );

   round_sat_mul #(.IN_W(STATE_W), .SHIFT(B_PREC), .OUT_W(STATE_W)) u_mul_b1 (
      .din  (s1_vp),
      .coef (B1),
      .dout (b1_term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld <= 1'b0;
         s2_b0  <= '0;
         s2_b1  <= '0;
      end else if (clear) begin
         s2_vld <= 1'b0;
      end else if (!stall) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_b0 <= b0_term;
            s2_b1 <= b1_term;
         end
      end
   end

   // S2: sum and saturate into the output register
   assign y_sum = 32'(s2_b0) + 32'(s2_b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (clear) begin
         out_valid <= 1'b0;
      end else if (!stall) begin
         out_valid <= s2_vld;
         if (s2_vld)
            out_data <= sat9(y_sum);
      end
   end

endmodule

// File: tb/tb_filter_chroma_deemphasis.sv
// Bench for filter_chroma_deemphasis: vector table, directed corner sequences, random traffic vs a queue model.
module tb_filter_chroma_deemphasis;
   import secam_filter_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic signed [8:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic signed [8:0] out_data;

   int errors = 0;
   int checks = 0;

   int mv = 0;        // model v[n-1]
   int exp_q[$];      // expected outputs, in order
   int obs[$];        // observed outputs of the current phase

   typedef struct {
      bit clr;
      bit iv;
      int x;
      bit ordy;
      bit exp_ov;
      int exp_dat;
      bit exp_ir;
   } vec_t;

   vec_t tbl[10];

   filter_chroma_deemphasis dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   function automatic int rnd_m(input longint p, input int s);
      return int'((p + (longint'(1) << (s - 1))) >>> s);
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   task automatic model_push(input int x);
      int v;
      int y;
      v = clamp(x + rnd_m(longint'(A1) * mv, A_PREC_DEF), -1024, 1023);
      y = clamp(rnd_m(longint'(B0) * v, B_PREC_DEF) + rnd_m(longint'(B1) * mv, B_PREC_DEF), -256, 255);
      exp_q.push_back(y);
      mv = v;
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Inputs for this cycle are already driven; settle, score the coming edge, then advance.
   task automatic tick();
      int e;
      #1;
      if (out_valid && out_ready) begin
         obs.push_back(int'(out_data));
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0d required=none", out_data);
         end else begin
            e = exp_q.pop_front();
            check("scoreboard", int'(out_data), e);
         end
      end
      if (in_valid && in_ready)
         model_push(int'(in_data));
      if (clear) begin
         mv = 0;
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x);
      in_valid = 1'b1;
      in_data  = 9'(x);
      tick();
   endtask

   task automatic do_clear();
      clear    = 1'b1;
      in_valid = 1'b0;
      tick();
      clear = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++)
         tick();
      repeat (3) tick();
      check("drain_pending", exp_q.size(), 0);
   endtask

   task automatic impulse_and_check(input string tag);
      int ref_imp[5];
      ref_imp = '{31, 17, 13, 10, 7};
      obs.delete();
      send(100);
      repeat (4) send(0);
      drain();
      check({tag, "_count"}, obs.size(), 5);
      for (int i = 0; i < 5 && i < obs.size(); i++)
         check($sformatf("%s_y%0d", tag, i), obs[i], ref_imp[i]);
   endtask

   initial begin
      int bad;
      int held;

      rst       = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      tbl[0] = '{0, 1, 100, 1, 0, 0,  1};
      tbl[1] = '{0, 1, 0,   1, 0, 0,  1};
      tbl[2] = '{0, 1, 0,   1, 0, 0,  1};
      tbl[3] = '{0, 1, 0,   1, 1, 31, 1};
      tbl[4] = '{0, 1, 0,   1, 1, 17, 1};
      tbl[5] = '{0, 0, 0,   1, 1, 13, 1};
      tbl[6] = '{0, 0, 0,   1, 1, 10, 1};
      tbl[7] = '{0, 0, 0,   1, 1, 7,  1};
      tbl[8] = '{0, 0, 0,   1, 0, 0,  1};
      tbl[9] = '{0, 0, 0,   0, 0, 0,  1};

      // Reset state
      @(posedge clk);
      #1;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_data", int'(out_data), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_in_ready", int'(in_ready), 1);

      // Impulse from reset, table-driven with exact latency
      for (int i = 0; i < 10; i++) begin
         clear     = tbl[i].clr;
         in_valid  = tbl[i].iv;
         in_data   = 9'(tbl[i].x);
         out_ready = tbl[i].ordy;
         tick();
         check($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].exp_ov));
         check($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].exp_ir));
         if (tbl[i].exp_ov)
            check($sformatf("tbl%0d_out_data", i), int'(out_data), tbl[i].exp_dat);
      end
      drain();

      // Zero stream
      do_clear();
      obs.delete();
      repeat (100) send(0);
      drain();
      bad = 0;
      foreach (obs[i]) if (obs[i] != 0) bad++;
      check("zero_stream_count", obs.size(), 100);
      check("zero_stream_nonzero", bad, 0);

      // DC step +100
      do_clear();
      obs.delete();
      repeat (200) send(100);
      drain();
      bad = 0;
      for (int i = obs.size() - 32; i < obs.size(); i++)
         if (i >= 0 && (obs[i] < 98 || obs[i] > 102)) bad++;
      check("dc100_count", obs.size(), 200);
      check("dc100_settle", bad, 0);

      // DC step +255
      do_clear();
      obs.delete();
      repeat (200) send(255);
      drain();
      bad = 0;
      foreach (obs[i]) if (obs[i] < 0 || obs[i] > 255) bad++;
      check("dc255_range", bad, 0);

      // Backpressure mid-stream
      do_clear();
      for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 511)) - 256);
      out_ready = 1'b0;
      held = int'(out_data);
      for (int i = 0; i < 5; i++) begin
         send(int'($urandom_range(0, 511)) - 256);
         check($sformatf("stall%0d_out_data", i), int'(out_data), held);
         check($sformatf("stall%0d_out_valid", i), int'(out_valid), 1);
         check($sformatf("stall%0d_in_ready", i), int'(in_ready), 0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 511)) - 256);
      drain();

      // Clear colliding with a valid input mid-stream
      for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 511)) - 256);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 9'sd77;
      #1;
      check("clear_in_ready", int'(in_ready), 0);
      tick();
      clear = 1'b0;
      check("clear_out_valid", int'(out_valid), 0);
      impulse_and_check("clear_impulse");

      // Reset while three samples are in flight
      send(50);
      send(60);
      send(70);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_out_valid", int'(out_valid), 0);
      mv = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      obs.delete();
      repeat (8) tick();
      check("rst_no_emit", obs.size(), 0);
      impulse_and_check("rst_impulse");

      // Random traffic with random backpressure and occasional clears
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 9'(int'($urandom_range(0, 511)) - 256);
         out_ready = ($urandom_range(0, 3) != 0);
         clear     = ($urandom_range(0, 99) == 0);
         tick();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/filter_chroma_deemphasis.md
FILTER_CHROMA_DEEMPHASIS -- requirements
Module: filter_chroma_deemphasis

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 SHALL expose ports:
  clk        input   1  sample clock, all logic on rising edge
  rst        input   1  asynchronous active-high reset
  clear      input   1  synchronous flush of filter state and pipeline
  in_valid   input   1  in_data carries a sample
  in_ready   output  1  block accepts a sample this cycle
  in_data    input   9  signed demodulated chroma (two's complement)
  out_valid  output  1  out_data carries a sample
  out_ready  input   1  sink accepts out_data this cycle
  out_data   output  9  signed de-emphasized chroma
REQ-003 SHALL take parameters (default, meaning):
  A_PREC, 8, fractional bits of A1
  B_PREC, 8, fractional bits of B0/B1

Function
REQ-004 SHALL implement the inverse of the transmit pre-emphasis as a first-order IIR:
  v[n] = sat11(x[n] + rnd(A1*v[n-1], A_PREC))
  y[n] = sat9(rnd(B0*v[n], B_PREC) + rnd(B1*v[n-1], B_PREC)).
REQ-005 SHALL define rnd(p,s) = (p + 2^(s-1)) arithmetic-shift-right s, on products of at least 24 bits.
REQ-006 SHALL clamp sat11 to [-1024,1023] and sat9 to [-256,255]; no two's-complement wrap.
REQ-007 SHALL advance v[n-1] only on an accepted input (in_valid & in_ready).
REQ-008 SHALL use a 3-stage pipeline: S0 input register, S1 state update and multiplies, S2 sum/saturate into out_data.
REQ-009 SHALL present a sample accepted at edge k on out_data with out_valid=1 after edge k+3 when out_ready stays 1.
REQ-010 SHALL stall globally: stall = out_valid & ~out_ready; in_ready = ~stall & ~clear.
REQ-011 SHALL hold out_data, out_valid and all stage registers and state constant while stalled.
REQ-012 SHALL ensure no sample is lost or duplicated under any out_ready pattern.
REQ-013 SHALL deassert out_valid after an output handshake when no new sample follows.
REQ-014 SHALL, on clear=1, zero v[n-1], zero every stage valid bit and set out_valid=0 on the next edge, regardless of stall.
REQ-015 SHALL give clear priority over a simultaneous in_valid; in_ready=0 that cycle and the sample is not consumed.
REQ-016 SHALL reach a DC gain of 1.0 within ±2 LSB, given the package coefficients satisfy (B0+B1)/(2^B_PREC - A1) = 1.

Reset
REQ-017 SHALL, while rst=1, force out_data=0, out_valid=0, v[n-1]=0 and all stage valid bits to 0.
REQ-018 SHALL drive in_ready=1 from the first edge after rst falls, with clear=0.
REQ-019 SHALL take reset asserted mid-stream immediately; in-flight samples are discarded and are not emitted after release.

Structure
REQ-020 SHALL take A1, B0, B1 and the precisions from shared package secam_filter_pkg, alongside the pre-emphasis constants.
REQ-021 SHALL place rnd and the saturation helpers in secam_filter_pkg as automatic functions.
REQ-022 SHALL instantiate one sub-module, round_sat_mul, to perform the multiply, round and saturate; it is instantiated for B0, B1 and A1.
REQ-023 SHALL carry A1 with the same sign convention as the pre-emphasis block; the sign is documented once in the package.

Verification
REQ-024 Zero stream: in_data=0 for 100 samples -> out_data=0 on every out_valid.
REQ-025 Impulse: one sample of +100 after clear, then zeros -> first output = sat9(rnd(B0*100,B_PREC)); following outputs match a bit-exact reference model.
REQ-026 DC step of +100 held 200 samples -> last 32 outputs in [98,102]; +255 held -> out_data never below 0 and never above 255.
REQ-027 Backpressure: out_ready=0 for 5 cycles mid-stream -> out_data stable and in_ready=0 during the stall; output sequence identical to an unstalled run.
REQ-028 Clear with in_valid=1 mid-stream -> that sample is not accepted; out_valid=0 next cycle; next output equals the impulse response from a zero state.
REQ-029 rst pulsed while 3 samples are in flight -> none emitted; the post-reset output sequence equals a fresh run.
